// File: rtl/reg_wb_arbiter_if.sv
// Write-back bus between the two requesters, the arbiter and the register
// file write/read ports.
//
// Handshake: on a rising clock edge a request on port N is accepted when
// pN_valid && pN_ready are both high. pN_ready depends only on whether that
// port's FIFO is full, never on what happens in the same cycle. The requester
// may change valid/addr/data only after an edge. WE3/A3/WD3 are registered
// outputs. hz1/hz2 are combinational functions of A1/A2 and the pending writes.
interface reg_wb_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              p0_valid;
  logic              p0_ready;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_data;
  logic              p1_valid;
  logic              p1_ready;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_data;
  logic              WE3;
  logic [ADDR_W-1:0] A3;
  logic [DATA_W-1:0] WD3;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic              hz1;
  logic              hz2;

  // Arbiter side
  modport slave (
    input  p0_valid, p0_addr, p0_data,
    input  p1_valid, p1_addr, p1_data,
    input  A1, A2,
    output p0_ready, p1_ready,
    output WE3, A3, WD3,
    output hz1, hz2
  );

  // Requester / register-file side
  modport master (
    output p0_valid, p0_addr, p0_data,
    output p1_valid, p1_addr, p1_data,
    output A1, A2,
    input  p0_ready, p1_ready,
    input  WE3, A3, WD3,
    input  hz1, hz2
  );
endinterface

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: two write-back requesters (port 0 = ALU, port 1 = load)
// share the register file's single write port. Each port has a DEPTH-entry
// FIFO; heads drain through a round-robin arbiter, one write per cycle.
// Writes to register 0 are accepted and dropped. Read addresses A1/A2 are
// snooped and flagged when they hit any accepted-but-uncommitted write.
//
// Optional feature macro: WB_ARB_STATS_EN
//   defined   -> conflict_cnt counts cycles with both FIFOs non-empty
//                (saturating at 16'hFFFF)
//   undefined -> conflict_cnt is tied to zero
module reg_wb_arbiter #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  reg_wb_arbiter_if.slave     bus,
  output logic                idle,
  output logic [15:0]         conflict_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage and bookkeeping, index [port][entry]
  logic [ADDR_W-1:0] addr_q [2][DEPTH];
  logic [ADDR_W-1:0] addr_d [2][DEPTH];
  logic [DATA_W-1:0] data_q [2][DEPTH];
  logic [DATA_W-1:0] data_d [2][DEPTH];
  logic [DEPTH-1:0]  vld_q [2];
  logic [DEPTH-1:0]  vld_d [2];
  logic [PTR_W-1:0]  wr_ptr_q [2];
  logic [PTR_W-1:0]  wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2];
  logic [PTR_W-1:0]  rd_ptr_d [2];
  logic [CNT_W-1:0]  cnt_q [2];
  logic [CNT_W-1:0]  cnt_d [2];

  // Registered write port and arbitration history (1 = port 1 granted last)
  logic              we3_q, we3_d;
  logic [ADDR_W-1:0] a3_q, a3_d;
  logic [DATA_W-1:0] wd3_q, wd3_d;
  logic              last_grant_q, last_grant_d;

  logic              in_valid [2];
  logic [ADDR_W-1:0] in_addr [2];
  logic [DATA_W-1:0] in_data [2];
  logic [1:0]        ne;
  logic [1:0]        full;
  logic [1:0]        push;
  logic [1:0]        grant;
  logic              hz1, hz2;

  // Port view as arrays so both FIFOs share one description
  always_comb begin
    in_valid[0] = bus.p0_valid;
    in_addr[0]  = bus.p0_addr;
    in_data[0]  = bus.p0_data;
    in_valid[1] = bus.p1_valid;
    in_addr[1]  = bus.p1_addr;
    in_data[1]  = bus.p1_data;
  end

  // Status, push qualification (register 0 dropped) and round-robin grant
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      ne[p]   = (cnt_q[p] != '0);
      full[p] = (cnt_q[p] == CNT_W'(DEPTH));
      push[p] = in_valid[p] && !full[p] && (in_addr[p] != '0);
    end
    grant[0] = ne[0] && (!ne[1] || last_grant_q);
    grant[1] = ne[1] && (!ne[0] || !last_grant_q);
  end

  // Next state: FIFO push/pop, write-port load, grant history
  always_comb begin
    addr_d       = addr_q;
    data_d       = data_q;
    vld_d        = vld_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    we3_d        = 1'b0;
    a3_d         = a3_q;
    wd3_d        = wd3_q;
    last_grant_d = last_grant_q;
    for (int p = 0; p < 2; p++) begin
      // A pop clears the head; a push never targets the head unless empty,
      // in which case no pop happens, so the order of these two is safe.
      if (grant[p]) begin
        vld_d[p][rd_ptr_q[p]] = 1'b0;
        rd_ptr_d[p]           = rd_ptr_q[p] + PTR_W'(1);
        we3_d                 = 1'b1;
        a3_d                  = addr_q[p][rd_ptr_q[p]];
        wd3_d                 = data_q[p][rd_ptr_q[p]];
        last_grant_d          = (p == 1);
      end
      if (push[p]) begin
        addr_d[p][wr_ptr_q[p]] = in_addr[p];
        data_d[p][wr_ptr_q[p]] = in_data[p];
        vld_d[p][wr_ptr_q[p]]  = 1'b1;
        wr_ptr_d[p]            = wr_ptr_q[p] + PTR_W'(1);
      end
      cnt_d[p] = cnt_q[p] + CNT_W'(push[p]) - CNT_W'(grant[p]);
    end
  end

  // State registers; reset discards all pending writes at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < DEPTH; i++) begin
          addr_q[p][i] <= '0;
          data_q[p][i] <= '0;
        end
        vld_q[p]    <= '0;
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
      we3_q        <= 1'b0;
      a3_q         <= '0;
      wd3_q        <= '0;
      last_grant_q <= 1'b1;
    end else begin
      addr_q       <= addr_d;
      data_q       <= data_d;
      vld_q        <= vld_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      we3_q        <= we3_d;
      a3_q         <= a3_d;
      wd3_q        <= wd3_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Read-after-write snoop against queued entries and the in-flight write
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    if (bus.A1 != '0 && we3_q && a3_q == bus.A1) hz1 = 1'b1;
    if (bus.A2 != '0 && we3_q && a3_q == bus.A2) hz2 = 1'b1;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (bus.A1 != '0 && vld_q[p][i] && addr_q[p][i] == bus.A1) hz1 = 1'b1;
        if (bus.A2 != '0 && vld_q[p][i] && addr_q[p][i] == bus.A2) hz2 = 1'b1;
      end
    end
  end

  assign bus.p0_ready = !full[0];
  assign bus.p1_ready = !full[1];
  assign bus.WE3      = we3_q;
  assign bus.A3       = a3_q;
  assign bus.WD3      = wd3_q;
  assign bus.hz1      = hz1;
  assign bus.hz2      = hz2;
  assign idle         = !ne[0] && !ne[1] && !we3_q;

`ifdef WB_ARB_STATS_EN
  logic [15:0] conflict_q, conflict_d;

  // Saturating count of cycles where both ports contend
  always_comb begin
    conflict_d = conflict_q;
    if (ne[0] && ne[1] && conflict_q != 16'hFFFF) conflict_d = conflict_q + 16'd1;
  end

  // Contention counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_q <= '0;
    else       conflict_q <= conflict_d;
  end

  assign conflict_cnt = conflict_q;
`else
  assign conflict_cnt = '0;
`endif

endmodule
